// File: rtl/rram_xbar_ctrl.sv
// Crossbar RRAM row controller: sequences row writes (settle, pulse, hold) and
// column-multiplexed row reads through a shared ADC bank with a valid/ready result port.
module rram_xbar_ctrl #(
    parameter int unsigned ROWS          = 1024,
    parameter int unsigned COLS          = 1024,
    parameter int unsigned NUM_ADCS      = 32,
    parameter int unsigned ADC_BITS      = 4,
    parameter int unsigned WR_CYCLES     = 100,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned MUX = COLS / NUM_ADCS,
    localparam int unsigned SW  = (MUX > 1) ? $clog2(MUX) : 1,
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned DW  = NUM_ADCS * ADC_BITS
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            CMD_VALID,
    output logic            CMD_READY,
    input  logic            CMD_OP,
    input  logic [RW-1:0]   CMD_ROW,
    input  logic [COLS-1:0] CMD_DATA,
    output logic [ROWS-1:0] WL,
    output logic [COLS-1:0] BL,
    output logic            WREN,
    output logic            RDEN,
    output logic [SW-1:0]   ADCSEL,
    input  logic [DW-1:0]   ADCOUT,
    output logic            RD_VALID,
    input  logic            RD_READY,
    output logic [DW-1:0]   RD_DATA,
    output logic [SW-1:0]   RD_SEL,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR
);

    localparam int unsigned CNT_MAX = (WR_CYCLES > SETTLE_CYCLES) ? WR_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [ROWS-1:0] WL_ONE = ROWS'(1);

    typedef enum logic [2:0] {
        StIdle, StWSet, StWPulse, StWHold, StRSet, StRCap, StROut, StFin
    } state_e;

    state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [ROWS-1:0] wl_q, wl_d;
    logic [COLS-1:0] bl_q, bl_d;
    logic            wren_q, wren_d;
    logic            rden_q, rden_d;
    logic [SW-1:0]   adcsel_q, adcsel_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [SW-1:0]   rd_sel_q, rd_sel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            row_oob;

    assign row_oob = 32'(CMD_ROW) >= ROWS;

    // Output registers are loaded with the values belonging to the next state,
    // so every output lines up with the state it describes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        wl_d       = wl_q;
        bl_d       = bl_q;
        wren_d     = 1'b0;
        rden_d     = rden_q;
        adcsel_d   = adcsel_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_sel_d   = rd_sel_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    if (row_oob) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        cnt_d    = '0;
                        sel_d    = '0;
                        adcsel_d = '0;
                        wl_d     = WL_ONE << CMD_ROW;
                        if (CMD_OP) begin
                            state_d = StRSet;
                            bl_d    = '0;
                            rden_d  = 1'b1;
                        end else begin
                            state_d = StWSet;
                            bl_d    = CMD_DATA;
                        end
                    end
                end
            end
            StWSet: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StWPulse;
                    wren_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWPulse: begin
                if (cnt_q == CW'(WR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StWHold;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    wren_d = 1'b1;
                end
            end
            StWHold: begin
                state_d = StFin;
                wl_d    = '0;
                bl_d    = '0;
                done_d  = 1'b1;
            end
            StRSet: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StRCap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRCap: begin
                rd_data_d  = ADCOUT;
                rd_sel_d   = sel_q;
                rd_valid_d = 1'b1;
                state_d    = StROut;
            end
            StROut: begin
                // WL and RDEN stay up through stalls; only the final group releases them.
                if (RD_READY) begin
                    rd_valid_d = 1'b0;
                    if (sel_q == SW'(MUX - 1)) begin
                        state_d  = StFin;
                        wl_d     = '0;
                        rden_d   = 1'b0;
                        adcsel_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        sel_d    = sel_q + 1'b1;
                        adcsel_d = sel_q + 1'b1;
                        state_d  = StRSet;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sel_q      <= '0;
            wl_q       <= '0;
            bl_q       <= '0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            adcsel_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_sel_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            wl_q       <= wl_d;
            bl_q       <= bl_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            adcsel_q   <= adcsel_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_sel_q   <= rd_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign CMD_READY = (state_q == StIdle);
    assign WL        = wl_q;
    assign BL        = bl_q;
    assign WREN      = wren_q;
    assign RDEN      = rden_q;
    assign ADCSEL    = adcsel_q;
    assign RD_VALID  = rd_valid_q;
    assign RD_DATA   = rd_data_q;
    assign RD_SEL    = rd_sel_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_rram_xbar_ctrl.sv
// Bench for rram_xbar_ctrl: directed and random commands checked against a
// cycle-count model of the write/read sequences and a replicated-sel ADC model.
module tb_rram_xbar_ctrl;

    localparam int unsigned ROWS          = 1000;
    localparam int unsigned COLS          = 1024;
    localparam int unsigned NUM_ADCS      = 32;
    localparam int unsigned ADC_BITS      = 4;
    localparam int unsigned WR_CYCLES     = 100;
    localparam int unsigned SETTLE_CYCLES = 2;
    localparam int unsigned MUX           = COLS / NUM_ADCS;
    localparam int unsigned SW            = 5;
    localparam int unsigned RW            = 10;
    localparam int unsigned DW            = NUM_ADCS * ADC_BITS;

    logic            CLK;
    logic            RESET_N;
    logic            CMD_VALID;
    logic            CMD_READY;
    logic            CMD_OP;
    logic [RW-1:0]   CMD_ROW;
    logic [COLS-1:0] CMD_DATA;
    logic [ROWS-1:0] WL;
    logic [COLS-1:0] BL;
    logic            WREN;
    logic            RDEN;
    logic [SW-1:0]   ADCSEL;
    logic [DW-1:0]   ADCOUT;
    logic            RD_VALID;
    logic            RD_READY;
    logic [DW-1:0]   RD_DATA;
    logic [SW-1:0]   RD_SEL;
    logic            BUSY;
    logic            DONE;
    logic            ERR;

    logic [DW-1:0]   adc_mask;
    int total;
    int bad;

    rram_xbar_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .NUM_ADCS(NUM_ADCS), .ADC_BITS(ADC_BITS),
        .WR_CYCLES(WR_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ROW(CMD_ROW), .CMD_DATA(CMD_DATA), .WL(WL), .BL(BL),
        .WREN(WREN), .RDEN(RDEN), .ADCSEL(ADCSEL), .ADCOUT(ADCOUT), .RD_VALID(RD_VALID),
        .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_SEL(RD_SEL), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Array model: each channel reports the selected group index, xored with a per-command mask.
    always_comb begin
        ADCOUT = '0;
        for (int k = 0; k < NUM_ADCS; k++)
            ADCOUT[k*ADC_BITS +: ADC_BITS] = ADCSEL[ADC_BITS-1:0] ^ adc_mask[k*ADC_BITS +: ADC_BITS];
    end

    function automatic logic [DW-1:0] exp_word(input int sel);
        logic [DW-1:0] w;
        logic [ADC_BITS-1:0] s;
        s = ADC_BITS'(sel);
        for (int k = 0; k < NUM_ADCS; k++)
            w[k*ADC_BITS +: ADC_BITS] = s ^ adc_mask[k*ADC_BITS +: ADC_BITS];
        return w;
    endfunction

    function automatic logic [ROWS-1:0] onehot(input int row);
        logic [ROWS-1:0] v;
        v = '0;
        v[row] = 1'b1;
        return v;
    endfunction

    function automatic logic [COLS-1:0] rand_cols();
        logic [COLS-1:0] d;
        for (int w = 0; w < COLS / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_mask();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [COLS-1:0] obs, input logic [COLS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // A write occupies SETTLE + WR + hold + fin cycles; the last of them is the DONE cycle.
    task automatic run_write(input int row, input logic [COLS-1:0] data, input bit hold_valid);
        int last;
        int n_wren, wl_bad, bl_bad, wren_bad, done_bad, other_bad;
        last = SETTLE_CYCLES + WR_CYCLES + 2;
        n_wren = 0; wl_bad = 0; bl_bad = 0; wren_bad = 0; done_bad = 0; other_bad = 0;
        CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_ROW = RW'(row); CMD_DATA = data;
        tick();
        if (hold_valid) begin
            CMD_OP = 1'b1; CMD_ROW = RW'(7); CMD_DATA = ~data;
        end else begin
            CMD_VALID = 1'b0;
        end
        for (int i = 1; i <= last; i++) begin
            if (WL !== ((i == last) ? '0 : onehot(row))) wl_bad++;
            if (BL !== ((i == last) ? '0 : data)) bl_bad++;
            if (WREN !== (i > SETTLE_CYCLES && i <= SETTLE_CYCLES + WR_CYCLES)) wren_bad++;
            if (DONE !== (i == last)) done_bad++;
            if (BUSY !== 1'b1 || RDEN !== 1'b0 || CMD_READY !== 1'b0 || ERR !== 1'b0 ||
                ADCSEL !== '0) other_bad++;
            if (WREN === 1'b1) n_wren++;
            tick();
        end
        chk("wr_wl", COLS'(wl_bad), '0);
        chk("wr_bl", COLS'(bl_bad), '0);
        chk("wr_wren_timing", COLS'(wren_bad), '0);
        chk("wr_wren_len", COLS'(n_wren), COLS'(WR_CYCLES));
        chk("wr_done", COLS'(done_bad), '0);
        chk("wr_busy_misc", COLS'(other_bad), '0);
        chk("wr_idle_after", {BUSY, DONE, CMD_READY, WREN}, 4'b0010);
    endtask

    // mode 0: always ready; 1: ten stalled beats at group 3; 2: random ready.
    task automatic run_read(input int row, input int mode, input logic [DW-1:0] mask);
        int exp_sel, beats, stall, n_busy, hold_bad, sel_bad, beat_bad, fin_bad;
        bit done_seen, prev_hs;
        exp_sel = 0; beats = 0; stall = 0; n_busy = 0;
        hold_bad = 0; sel_bad = 0; beat_bad = 0; fin_bad = 0;
        done_seen = 1'b0; prev_hs = 1'b0;
        adc_mask = mask;
        CMD_VALID = 1'b1; CMD_OP = 1'b1; CMD_ROW = RW'(row); CMD_DATA = rand_cols();
        RD_READY = 1'b0;
        tick();
        CMD_VALID = 1'b0;
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            if (BUSY === 1'b1) n_busy++;
            if (DONE === 1'b1) begin
                done_seen = 1'b1;
                if (WL !== '0 || RDEN !== 1'b0 || ADCSEL !== '0 || BL !== '0 ||
                    RD_VALID !== 1'b0 || BUSY !== 1'b1 || WREN !== 1'b0) fin_bad++;
            end else begin
                if (WL !== onehot(row) || RDEN !== 1'b1 || WREN !== 1'b0 || BL !== '0 ||
                    CMD_READY !== 1'b0 || BUSY !== 1'b1 || ERR !== 1'b0) hold_bad++;
                if (ADCSEL !== SW'(exp_sel)) sel_bad++;
                if (prev_hs && RD_VALID !== 1'b0) beat_bad++;
                prev_hs = 1'b0;
                case (mode)
                    0: RD_READY = 1'b1;
                    1: RD_READY = !(exp_sel == 3 && stall < 10);
                    default: RD_READY = 1'($urandom_range(0, 1));
                endcase
                if (RD_VALID === 1'b1) begin
                    if (RD_SEL !== SW'(exp_sel) || RD_DATA !== exp_word(exp_sel)) beat_bad++;
                    if (RD_READY) begin
                        beats++;
                        exp_sel++;
                        prev_hs = 1'b1;
                    end else begin
                        stall++;
                    end
                end
            end
            tick();
        end
        RD_READY = 1'b0;
        chk("rd_done_seen", COLS'(done_seen), COLS'(1));
        chk("rd_beats", COLS'(beats), COLS'(MUX));
        chk("rd_beat_data", COLS'(beat_bad), '0);
        chk("rd_hold", COLS'(hold_bad), '0);
        chk("rd_adcsel", COLS'(sel_bad), '0);
        chk("rd_fin", COLS'(fin_bad), '0);
        chk("rd_busy_len", COLS'(n_busy), COLS'(MUX * (SETTLE_CYCLES + 2) + stall + 1));
        chk("rd_idle_after", {BUSY, DONE, RD_VALID, RDEN}, 4'b0000);
    endtask

    task automatic run_err(input int row);
        CMD_VALID = 1'b1; CMD_OP = 1'($urandom_range(0, 1)); CMD_ROW = RW'(row);
        CMD_DATA = rand_cols();
        tick();
        CMD_VALID = 1'b0;
        chk("err_pulse", {ERR, DONE, WREN, RDEN, BUSY}, 5'b11000);
        chk("err_wl", WL, '0);
        tick();
        chk("err_clear", {ERR, DONE, BUSY, WREN, RDEN}, 5'b00000);
        chk("err_wl_after", WL, '0);
    endtask

    initial begin
        int r;
        total = 0;
        bad = 0;
        RESET_N = 1'b0;
        CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_ROW = '0; CMD_DATA = '0;
        RD_READY = 1'b0; adc_mask = '0;
        tick();
        tick();
        chk("rst_ctrl", {WREN, RDEN, RD_VALID, BUSY, DONE, ERR, CMD_READY}, 7'b0000001);
        chk("rst_wl", WL, '0);
        chk("rst_bl", BL, '0);
        chk("rst_sel", {ADCSEL, RD_SEL}, '0);
        chk("rst_rd_data", RD_DATA, '0);
        RESET_N = 1'b1;
        tick();

        run_write(0, '1, 1'b0);
        run_read(5, 0, '0);
        run_read(9, 1, rand_mask());
        run_err(1010);
        run_err(ROWS);
        run_write(ROWS - 1, rand_cols(), 1'b1);
        run_read(7, 2, rand_mask());

        // Abort a write in the middle of its pulse.
        CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_ROW = RW'(3); CMD_DATA = rand_cols();
        tick();
        CMD_VALID = 1'b0;
        repeat (SETTLE_CYCLES + 49) tick();
        chk("abort_pre_wren", {WREN, BUSY}, 2'b11);
        RESET_N = 1'b0;
        #1;
        chk("abort_now", {WREN, RDEN, BUSY, DONE}, 4'b0000);
        chk("abort_wl", WL, '0);
        repeat (3) begin
            tick();
            chk("abort_no_done", {DONE, WREN}, 2'b00);
        end
        #2 RESET_N = 1'b1;
        tick();
        run_read(5, 0, rand_mask());

        for (int n = 0; n < 6; n++) begin
            r = $urandom_range(0, 1023);
            if (r >= ROWS) run_err(r);
            else if ($urandom_range(0, 1) == 0) run_write(r, rand_cols(), 1'b0);
            else run_read(r, $urandom_range(0, 2), rand_mask());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rram_xbar_ctrl.md
RRAM_XBAR_CTRL -- requirements
Module: rram_xbar_ctrl

Interface
REQ-001 SHALL provide parameter ROWS, default 1024, meaning the number of word lines.
REQ-002 SHALL provide parameter COLS, default 1024, meaning the number of bit lines.
REQ-003 SHALL provide parameter NUM_ADCS, default 32, meaning the number of ADC channels; COLS SHALL be a multiple of NUM_ADCS.
REQ-004 SHALL provide parameter ADC_BITS, default 4, meaning the ADC result width.
REQ-005 SHALL provide parameter WR_CYCLES, default 100, meaning the write-pulse length in cycles (>=1).
REQ-006 SHALL provide parameter SETTLE_CYCLES, default 2, meaning the WL/BL and ADCSEL settle time in cycles (>=1).
REQ-007 Derived: MUX=COLS/NUM_ADCS; SW=max(1,clog2(MUX)); RW=max(1,clog2(ROWS)).
REQ-008 SHALL have ports, one per line, as follows:
  CLK  in  1  sole clock, rising edge.
  RESET_N  in  1  asynchronous active-low reset.
  CMD_VALID  in  1  command request.
  CMD_READY  out  1  command accepted when high with CMD_VALID.
  CMD_OP  in  1  0=write row, 1=read row.
  CMD_ROW  in  RW  target word line.
  CMD_DATA  in  COLS  write data, ignored on read.
  WL  out  ROWS  one-hot word-line drive.
  BL  out  COLS  bit-line drive.
  WREN  out  1  array write pulse.
  RDEN  out  1  array read enable.
  ADCSEL  out  SW  column-group select.
  ADCOUT  in  NUM_ADCS*ADC_BITS  packed ADC results; channel k is at [k*ADC_BITS +: ADC_BITS].
  RD_VALID  out  1  read result available.
  RD_READY  in  1  result consumer ready.
  RD_DATA  out  NUM_ADCS*ADC_BITS  captured ADC word.
  RD_SEL  out  SW  group index of RD_DATA.
  BUSY  out  1  high whenever state is not IDLE.
  DONE  out  1  one-cycle pulse at command completion.
  ERR  out  1  one-cycle pulse on an out-of-range row.

Function
REQ-009 SHALL implement the states IDLE, W_SET, W_PULSE, W_HOLD, R_SET, R_CAP, R_OUT, FIN.
REQ-010 CMD_READY SHALL be high only in IDLE; a command is accepted on the cycle CMD_VALID&&CMD_READY, and CMD_OP, CMD_ROW and CMD_DATA are registered at acceptance.
REQ-011 If CMD_ROW>=ROWS, the controller SHALL stay in IDLE, pulse ERR and DONE on the next cycle, and never drive WL, WREN or RDEN.
REQ-012 Write SHALL proceed as follows: W_SET (WL=onehot(row), BL=data, WREN=0) for SETTLE_CYCLES cycles; then W_PULSE (WREN=1) for exactly WR_CYCLES cycles; then W_HOLD (WREN=0, WL/BL held) for 1 cycle; then FIN.
REQ-013 Read SHALL proceed as follows: R_SET (WL=onehot(row), BL=0, RDEN=1, ADCSEL=sel) for SETTLE_CYCLES cycles; then R_CAP, in which RD_DATA<=ADCOUT, RD_SEL<=sel and RD_VALID is set; then R_OUT.
REQ-014 In R_OUT, RD_VALID, RD_DATA and RD_SEL SHALL hold stable until RD_READY; on the handshake cycle RD_VALID SHALL drop next cycle, and the controller SHALL go to R_SET with sel+1 if sel<MUX-1, else to FIN.
REQ-015 sel SHALL start at 0 for each read; exactly MUX results SHALL be emitted in ascending RD_SEL order, and sel SHALL not wrap within a command.
REQ-016 RDEN and WL SHALL stay asserted continuously across all groups of a read, including stalls in R_OUT.
REQ-017 FIN SHALL last 1 cycle with WL=0, BL=0, WREN=0, RDEN=0, ADCSEL=0 and DONE=1, then return to IDLE.
REQ-018 WREN and RDEN SHALL never be high in the same cycle, and WL SHALL be all-zero or one-hot in every cycle.
REQ-019 All outputs SHALL be registered, with no combinational path from inputs to outputs other than CMD_READY, which is state-derived only.
REQ-020 CMD_VALID while BUSY SHALL be ignored without side effects.

Reset
REQ-021 On RESET_N low, asynchronously: state=IDLE, WL=0, BL=0, WREN=0, RDEN=0, ADCSEL=0, RD_VALID=0, RD_DATA=0, RD_SEL=0, BUSY=0, DONE=0, ERR=0, and all counters=0.
REQ-022 Reset mid-operation SHALL abort immediately with no DONE; the first command after release SHALL be accepted normally.

Verification
REQ-023 Write row 0 with CMD_DATA all ones at the defaults -> WL=1, BL all ones for 2 cycles, then WREN high for exactly 100 cycles, 1 hold cycle, DONE pulse; total BUSY = 104 cycles.
REQ-024 Read row 5 with ADCOUT model = sel replicated per channel and RD_READY=1 -> 32 RD_VALID beats, RD_SEL 0..31, each RD_DATA equal to {32{sel[3:0]}}, then DONE.
REQ-025 Read with RD_READY held low for 10 cycles at sel=3 -> RD_DATA/RD_SEL stable, RDEN stays 1, ADCSEL=3, and no skipped or duplicated beat.
REQ-026 With ROWS=1000 and CMD_ROW=1010 -> ERR and DONE pulse together, WL remains 0, WREN and RDEN remain 0.
REQ-027 Assert RESET_N low during W_PULSE cycle 50 -> WREN=0 and WL=0 immediately, no DONE; a following read completes normally.
REQ-028 Second CMD_VALID during a write -> not accepted, first command unaffected; accepted on the IDLE cycle after DONE.
